// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed on the accept edge and committed when the busy countdown expires.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        md_en,
   input  logic [2:0]  md_ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_result
);

   typedef enum logic {IDLE, RUN} state_e;
   typedef enum logic [2:0] {
      OP_MFLO, OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MTLO, OP_MTHI, OP_MFHI
   } op_e;

   state_e      state_q;
   op_e         op;
   logic        busy_q;
   logic [31:0] cnt_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] pend_hi_q, pend_lo_q;
   logic        pend_wr_q;

   logic [31:0] pend_hi_d, pend_lo_d;
   logic        pend_wr_d;
   logic [63:0] prod_u, prod_s;
   logic [31:0] a_mag, dvs, quo, rem;
   logic        is_div_s, neg_a, neg_b;

   assign op = op_e'(md_ctrl);

   // Low 64 bits of an unsigned multiply on sign-extended operands equal the signed product.
   assign prod_u = {32'b0, a} * {32'b0, b};
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly; divisor is
   // forced nonzero for b==0 since that result is discarded anyway.
   always_comb begin
      is_div_s  = (op == OP_DIV);
      neg_a     = is_div_s & a[31];
      neg_b     = is_div_s & b[31];
      a_mag     = neg_a ? (32'd0 - a) : a;
      dvs       = (b == 32'd0) ? 32'd1 : (neg_b ? (32'd0 - b) : b);
      quo       = a_mag / dvs;
      rem       = a_mag % dvs;
      pend_wr_d = 1'b1;
      pend_hi_d = '0;
      pend_lo_d = '0;
      case (op)
         OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
         OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
         OP_DIVU, OP_DIV: begin
            pend_lo_d = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
            pend_hi_d = neg_a ? (32'd0 - rem) : rem;
            pend_wr_d = (b != 32'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (md_en) begin
                  case (op)
                     OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= (op == OP_MULTU || op == OP_MULT) ?
                                     32'(MULT_CYCLES) : 32'(DIV_CYCLES);
                        pend_hi_q <= pend_hi_d;
                        pend_lo_q <= pend_lo_d;
                        pend_wr_q <= pend_wr_d;
                     end
                     OP_MTLO: lo_q <= a;
                     OP_MTHI: hi_q <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               cnt_q <= cnt_q - 32'd1;
               if (cnt_q == 32'd1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (pend_wr_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign md_result = (op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic results, moves, ignored ops and async reset.
module tb_md_unit;

   logic        clk;
   logic        reset_n;
   logic        md_en;
   logic [2:0]  md_ctrl;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo, md_result;

   int checks = 0;
   int errors = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .md_en(md_en), .md_ctrl(md_ctrl),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .md_result(md_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; the op is taken on the next posedge, returns at the following negedge.
   task automatic issue(input logic [2:0] ctrl, input logic [31:0] va, input logic [31:0] vb);
      md_en = 1'b1; md_ctrl = ctrl; a = va; b = vb;
      @(negedge clk);
      md_en = 1'b0;
   endtask

   // Counts negedges with busy high, bounded so a stuck unit cannot hang the run.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; md_en = 1'b0; md_ctrl = 3'd0; a = '0; b = '0;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      int n;
      issue(3'd1, 32'hFFFFFFFF, 32'd2);
      count_busy(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
      checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
      issue(3'd2, 32'hFFFFFFFD, 32'd4);
      count_busy(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFF4) begin errors++; $display("FAIL mult_lo: got %h expected fffffff4", lo); end
      issue(3'd1, 32'hFFFFFFFD, 32'd4);
      count_busy(n);
      checks++; if (hi !== 32'h00000003) begin errors++; $display("FAIL multu2_hi: got %h expected 00000003", hi); end
      checks++; if (lo !== 32'hFFFFFFF4) begin errors++; $display("FAIL multu2_lo: got %h expected fffffff4", lo); end
   endtask

   task automatic test_div;
      int n;
      issue(3'd4, 32'hFFFFFFF9, 32'd2);
      count_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      issue(3'd3, 32'd7, 32'd2);
      count_busy(n);
      checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 00000003", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
      issue(3'd4, 32'h80000000, 32'hFFFFFFFF);
      count_busy(n);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
      issue(3'd4, 32'd7, 32'hFFFFFFFE);
      count_busy(n);
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h expected 00000001", hi); end
   endtask

   task automatic test_move;
      int n;
      issue(3'd6, 32'h12345678, 32'd0);
      issue(3'd5, 32'h9ABCDEF0, 32'd0);
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h expected 12345678", hi); end
      checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo: got %h expected 9abcdef0", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL move_busy: got %b expected 0", busy); end
      md_ctrl = 3'd7; #1;
      checks++; if (md_result !== 32'h12345678) begin errors++; $display("FAIL mfhi_read: got %h expected 12345678", md_result); end
      md_ctrl = 3'd0; #1;
      checks++; if (md_result !== 32'h9ABCDEF0) begin errors++; $display("FAIL mflo_read: got %h expected 9abcdef0", md_result); end
      @(negedge clk);
      issue(3'd3, 32'd55, 32'd0);
      md_ctrl = 3'd7; #1;
      checks++; if (md_result !== 32'h12345678) begin errors++; $display("FAIL mfhi_busy: got %h expected 12345678", md_result); end
      count_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div0_cycles: got %0d expected 10", n); end
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL div0_hi: got %h expected 12345678", hi); end
      checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL div0_lo: got %h expected 9abcdef0", lo); end
   endtask

   task automatic test_ignore_busy;
      int n;
      issue(3'd1, 32'h00010000, 32'h00010000);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy1: got %b expected 1", busy); end
      issue(3'd6, 32'hDEADBEEF, 32'd0);
      checks++; if (hi === 32'hDEADBEEF) begin errors++; $display("FAIL ign_mthi: got %h expected not deadbeef", hi); end
      issue(3'd4, 32'd100, 32'd7);
      count_busy(n);
      checks++; if (n !== 3) begin errors++; $display("FAIL ign_cycles: got %0d expected 3 after 2 busy cycles", n); end
      checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL ign_hi: got %h expected 00000001", hi); end
      checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL ign_lo: got %h expected 00000000", lo); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_restart: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'd1, 32'd3, 32'd5);
      count_busy(n);
      issue(3'd3, 32'd100, 32'd7);
      checks++; if (lo !== 32'd15) begin errors++; $display("FAIL b2b_first_lo: got %h expected 0000000f", lo); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
      count_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL b2b_cycles: got %0d expected 10", n); end
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h expected 0000000e", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h expected 00000002", hi); end
   endtask

   task automatic test_async_reset;
      int n;
      issue(3'd4, 32'hFFFFFFF9, 32'd2);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL areset_hi: got %h expected 00000000", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL areset_lo: got %h expected 00000000", lo); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL post_reset_hilo: got %h_%h expected 00000000_00000000", hi, lo); end
      issue(3'd2, 32'hFFFFFFFD, 32'd4);
      count_busy(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL post_reset_mult_cycles: got %0d expected 5", n); end
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4) begin errors++; $display("FAIL post_reset_mult: got %h_%h expected ffffffff_fffffff4", hi, lo); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_move();
      test_ignore_busy();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
